// File: rtl/multibyte_add_ctrl.sv
// Multi-byte adder controller: sequences an external 8-bit ripple adder over
// NBYTES passes, least-significant byte first, and registers the W-bit sum.
module multibyte_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ovf,
    output logic [7:0]            add_in1,
    output logic [7:0]            add_in2,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_cin;
    logic          r_carry;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_ovf;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_cin    <= cin;
                        r_k      <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_result[8*r_k +: 8] <= add_sum;
                    r_carry              <= add_cout;
                    if (r_k == K_LAST) begin
                        // Overflow: like-signed operands giving a differently signed sum.
                        r_cout  <= add_cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (add_sum[7] != r_a[W-1]);
                        r_k     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Adder inputs are held at zero outside ADD to keep the adder quiet.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        add_in1 = '0;
        add_in2 = '0;
        add_cin = 1'b0;
        if (r_state == S_ADD) begin
            add_in1 = r_a[8*r_k +: 8];
            add_in2 = r_b[8*r_k +: 8];
            add_cin = (r_k == '0) ? r_cin : r_carry;
        end
    end

    assign busy   = (r_state == S_ADD);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Self-checking bench for multibyte_add_ctrl (NBYTES=4) with a behavioural
// 8-bit adder and an arithmetic reference model of the full W-bit add.
module tb_multibyte_add_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout, ovf;
    logic [W-1:0]  result;
    logic [7:0]    add_in1, add_in2, add_sum;
    logic          add_cin, add_cout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External ripple adder: purely combinational.
    assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {8'd0, add_cin};

    multibyte_add_ctrl #(.NBYTES(NBYTES)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .ovf     (ovf),
        .add_in1 (add_in1),
        .add_in2 (add_in2),
        .add_cin (add_cin),
        .add_sum (add_sum),
        .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " add_in1"}, 64'(add_in1), 64'd0);
        check({tag, " add_in2"}, 64'(add_in2), 64'd0);
        check({tag, " add_cin"}, 64'(add_cin), 64'd0);
    endtask

    // One complete operation. With pulse_start set, start is re-asserted with
    // fresh operands during the second pass and again in the done cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input bit pulse_start, input string tag);
        logic [63:0] s, mask, part;
        logic        exp_ovf;
        s       = 64'(av) + 64'(bv) + 64'(cv);
        exp_ovf = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);

        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
        for (int i = 0; i < NBYTES; i++) begin
            mask = (64'd1 << (8 * i)) - 64'd1;
            part = ((64'(av) & mask) + (64'(bv) & mask) + 64'(cv)) >> (8 * i);
            check($sformatf("%s p%0d busy", tag, i), 64'(busy), 64'd1);
            check($sformatf("%s p%0d done", tag, i), 64'(done), 64'd0);
            check($sformatf("%s p%0d in1", tag, i), 64'(add_in1), 64'(8'(av >> (8 * i))));
            check($sformatf("%s p%0d in2", tag, i), 64'(add_in2), 64'(8'(bv >> (8 * i))));
            check($sformatf("%s p%0d cin", tag, i), 64'(add_cin), 64'(part[0]));
            if (pulse_start && i == 1) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        check({tag, " result"}, 64'(result), 64'(s[W-1:0]));
        check({tag, " cout"}, 64'(cout), 64'(s[W]));
        check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
        check_quiet({tag, " done"});
        if (pulse_start) begin
            start = 1'b1; a = $urandom; b = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        check({tag, " idle done"}, 64'(done), 64'd0);
        check({tag, " hold result"}, 64'(result), 64'(s[W-1:0]));
        check({tag, " hold cout"}, 64'(cout), 64'(s[W]));
        check({tag, " hold ovf"}, 64'(ovf), 64'(exp_ovf));
        if (pulse_start) begin
            @(negedge clk);
            check({tag, " no 2nd op"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with start asserted to confirm reset wins.
        start = 1'b1; a = 32'h1234_5678; b = 32'h1;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst cout", 64'(cout), 64'd0);
        check("rst ovf", 64'(ovf), 64'd0);
        check_quiet("rst");
        start = 1'b0;
        rst   = 1'b0;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, "small");
        run_op(32'h0000_007F, 32'h0000_0001, 1'b1, 1'b0, "chain7f");
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "chainff");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "ripple");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "sovf");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "novf");
        run_op(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b1, "ignstart");

        // Reset asserted during the second pass.
        @(negedge clk);
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrst in pass", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst result", 64'(result), 64'd0);
        check_quiet("midrst");
        for (int i = 0; i < NBYTES + 1; i++) begin
            @(negedge clk);
            check($sformatf("midrst no done %0d", i), 64'(done), 64'd0);
            check($sformatf("midrst idle %0d", i), 64'(busy), 64'd0);
        end
        run_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0, "fresh");

        for (int n = 0; n < 20; n++)
            run_op($urandom, $urandom, 1'($urandom), 1'b0, $sformatf("rnd%0d", n));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
